regfile_wb_sched: RTL and testbench

//  Write-back scheduler and hazard scoreboard for the single-write-port register file.

---
 rtl/regfile_wb_sched.sv | 161 ++++++++++++++++
 tb/tb_regfile_wb_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_sched
// Description : Write-back arbiter and hazard scoreboard for a register file
//               with a single write port. ALU and LSU write-backs share the
//               port round-robin. One pending bit per architectural register
//               stalls issue on RAW and WAW hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_sched #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int AW       = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                issue_valid,
    input  logic [AW-1:0]       issue_rs1,
    input  logic [AW-1:0]       issue_rs2,
    input  logic                issue_use_rs1,
    input  logic                issue_use_rs2,
    input  logic [AW-1:0]       issue_rd,
    input  logic                issue_wr,
    output logic                issue_stall,
    input  logic                alu_valid,
    input  logic [AW-1:0]       alu_rd,
    input  logic [XLEN-1:0]     alu_data,
    output logic                alu_ready,
    input  logic                lsu_valid,
    input  logic [AW-1:0]       lsu_rd,
    input  logic [XLEN-1:0]     lsu_data,
    output logic                lsu_ready,
    output logic                rf_wr_en,
    output logic [AW-1:0]       rf_rd,
    output logic [XLEN-1:0]     rf_write_data,
    output logic [NUM_REGS-1:0] pending,
    output logic                err_spurious
);

    localparam logic [AW-1:0] ZERO_REG = '0;

    // Registered state
    logic                prefer_lsu_q, prefer_lsu_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [NUM_REGS-1:0] flushed_q, flushed_d;   // regs whose owner was flushed
    logic                flush_seen_q, flush_seen_d;
    logic                err_q, err_d;
    logic                rf_wr_en_q, rf_wr_en_d;
    logic [AW-1:0]       rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]     rf_data_q, rf_data_d;

    // Combinational intermediates
    logic                alu_grant;
    logic                lsu_grant;
    logic                grant;
    logic [AW-1:0]       wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic                wb_clear;
    logic                stall;
    logic                issue_fire;

    // Round-robin arbitration between ALU and LSU write-back requests
    always_comb begin
        alu_grant = alu_valid && (!lsu_valid || !prefer_lsu_q);
        lsu_grant = lsu_valid && (!alu_valid || prefer_lsu_q);
        grant     = alu_grant || lsu_grant;
        wb_rd     = alu_grant ? alu_rd   : lsu_rd;
        wb_data   = alu_grant ? alu_data : lsu_data;
        wb_clear  = grant && (wb_rd != ZERO_REG);
        if (alu_grant) begin
            prefer_lsu_d = 1'b1;
        end else if (lsu_grant) begin
            prefer_lsu_d = 1'b0;
        end else begin
            prefer_lsu_d = prefer_lsu_q;
        end
    end

    // Hazard detection uses only the registered scoreboard (no bypass of a same-cycle clear)
    always_comb begin
        stall = issue_valid &&
                ((issue_use_rs1 && pending_q[issue_rs1]) ||
                 (issue_use_rs2 && pending_q[issue_rs2]) ||
                 (issue_wr      && pending_q[issue_rd]));
        issue_fire = issue_valid && !stall && issue_wr && (issue_rd != ZERO_REG);
    end

    // Scoreboard next state: clear on write-back, set on issue, wipe on flush
    always_comb begin
        pending_d    = pending_q;
        flushed_d    = flushed_q;
        err_d        = err_q;
        flush_seen_d = flush;

        if (flush) begin
            // Whatever was outstanding may still write back; remember it so
            // that late write-back is not reported as spurious.
            flushed_d = flushed_q | pending_q;
            pending_d = '0;
            if (issue_fire) begin
                flushed_d[issue_rd] = 1'b1;
            end
        end else if (issue_fire) begin
            pending_d[issue_rd] = 1'b1;
            flushed_d[issue_rd] = 1'b0;
        end

        if (wb_clear) begin
            if (!pending_q[wb_rd] && !flushed_q[wb_rd] && !flush && !flush_seen_q) begin
                err_d = 1'b1;
            end
            pending_d[wb_rd] = 1'b0;
            flushed_d[wb_rd] = 1'b0;
        end

        pending_d[0] = 1'b0;
        flushed_d[0] = 1'b0;
    end

    // Write-port output register: loads on grant, write enable only for rd != x0
    always_comb begin
        rf_wr_en_d = wb_clear;
        rf_rd_d    = grant ? wb_rd   : rf_rd_q;
        rf_data_d  = grant ? wb_data : rf_data_q;
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prefer_lsu_q <= 1'b0;
            pending_q    <= '0;
            flushed_q    <= '0;
            flush_seen_q <= 1'b0;
            err_q        <= 1'b0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_q      <= '0;
            rf_data_q    <= '0;
        end else begin
            prefer_lsu_q <= prefer_lsu_d;
            pending_q    <= pending_d;
            flushed_q    <= flushed_d;
            flush_seen_q <= flush_seen_d;
            err_q        <= err_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_q      <= rf_rd_d;
            rf_data_q    <= rf_data_d;
        end
    end

    assign issue_stall   = stall;
    assign alu_ready     = alu_grant;
    assign lsu_ready     = lsu_grant;
    assign rf_wr_en      = rf_wr_en_q;
    assign rf_rd         = rf_rd_q;
    assign rf_write_data = rf_data_q;
    assign pending       = pending_q;
    assign err_spurious  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_sched
// Description : Directed self-checking bench for regfile_wb_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_sched;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int AW       = 5;

    logic                clk;
    logic                reset;
    logic                flush;
    logic                issue_valid;
    logic [AW-1:0]       issue_rs1;
    logic [AW-1:0]       issue_rs2;
    logic                issue_use_rs1;
    logic                issue_use_rs2;
    logic [AW-1:0]       issue_rd;
    logic                issue_wr;
    logic                issue_stall;
    logic                alu_valid;
    logic [AW-1:0]       alu_rd;
    logic [XLEN-1:0]     alu_data;
    logic                alu_ready;
    logic                lsu_valid;
    logic [AW-1:0]       lsu_rd;
    logic [XLEN-1:0]     lsu_data;
    logic                lsu_ready;
    logic                rf_wr_en;
    logic [AW-1:0]       rf_rd;
    logic [XLEN-1:0]     rf_write_data;
    logic [NUM_REGS-1:0] pending;
    logic                err_spurious;

    int n_checks;
    int n_errors;

    regfile_wb_sched #(
        .XLEN     (XLEN),
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_rd      (issue_rd),
        .issue_wr      (issue_wr),
        .issue_stall   (issue_stall),
        .alu_valid     (alu_valid),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .alu_ready     (alu_ready),
        .lsu_valid     (lsu_valid),
        .lsu_rd        (lsu_rd),
        .lsu_data      (lsu_data),
        .lsu_ready     (lsu_ready),
        .rf_wr_en      (rf_wr_en),
        .rf_rd         (rf_rd),
        .rf_write_data (rf_write_data),
        .pending       (pending),
        .err_spurious  (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush         = 1'b0;
        issue_valid   = 1'b0;
        issue_rs1     = '0;
        issue_rs2     = '0;
        issue_use_rs1 = 1'b0;
        issue_use_rs2 = 1'b0;
        issue_rd      = '0;
        issue_wr      = 1'b0;
        alu_valid     = 1'b0;
        alu_rd        = '0;
        alu_data      = '0;
        lsu_valid     = 1'b0;
        lsu_rd        = '0;
        lsu_data      = '0;
    endtask

    // Present a write-only issue to rd for one cycle
    task automatic issue_write(input logic [AW-1:0] rd);
        idle();
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_rd    = rd;
        #1;
        check("issue_no_stall", 64'(issue_stall), 64'd0);
        step();
    endtask

    logic [NUM_REGS-1:0] exp_pend;

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        reset = 1'b1;
        #12;
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_pending",  64'(pending),       64'd0);
        check("rst_wr_en",    64'(rf_wr_en),      64'd0);
        check("rst_rd",       64'(rf_rd),         64'd0);
        check("rst_data",     64'(rf_write_data), 64'd0);
        check("rst_err",      64'(err_spurious),  64'd0);
        step();

        // Round-robin: ALU and LSU both valid for four cycles, ALU preferred first
        for (int r = 10; r < 14; r++) issue_write(AW'(r));
        check("rr_pending", 64'(pending), 64'h0000_3C00);
        for (int k = 0; k < 4; k++) begin
            idle();
            alu_valid = 1'b1;
            lsu_valid = 1'b1;
            alu_rd    = (k < 2) ? AW'(10) : AW'(12);
            lsu_rd    = (k < 2) ? AW'(11) : AW'(13);
            alu_data  = 32'hA0 + 32'(k);
            lsu_data  = 32'hB0 + 32'(k);
            #1;
            check("rr_alu_ready", 64'(alu_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
            check("rr_lsu_ready", 64'(lsu_ready), (k % 2 == 0) ? 64'd0 : 64'd1);
            check("rr_one_ready", 64'(alu_ready & lsu_ready), 64'd0);
            step();
            check("rr_wr_en", 64'(rf_wr_en), 64'd1);
            case (k)
                0: begin check("rr_rd", 64'(rf_rd), 64'd10); check("rr_data", 64'(rf_write_data), 64'hA0); end
                1: begin check("rr_rd", 64'(rf_rd), 64'd11); check("rr_data", 64'(rf_write_data), 64'hB1); end
                2: begin check("rr_rd", 64'(rf_rd), 64'd12); check("rr_data", 64'(rf_write_data), 64'hA2); end
                default: begin check("rr_rd", 64'(rf_rd), 64'd13); check("rr_data", 64'(rf_write_data), 64'hB3); end
            endcase
        end
        idle();
        check("rr_pending_clear", 64'(pending), 64'd0);
        check("rr_err", 64'(err_spurious), 64'd0);

        // Write-back to x0: accepted, no write, no scoreboard effect
        alu_valid = 1'b1;
        alu_rd    = '0;
        alu_data  = 32'h1234;
        #1;
        check("x0_ready", 64'(alu_ready), 64'd1);
        step();
        idle();
        check("x0_wr_en",   64'(rf_wr_en),     64'd0);
        check("x0_pending", 64'(pending),      64'd0);
        check("x0_err",     64'(err_spurious), 64'd0);

        // RAW hazard on x5, released the cycle after the ALU grant
        issue_write(AW'(5));
        check("raw_pending", 64'(pending), 64'h0000_0020);
        idle();
        issue_valid   = 1'b1;
        issue_use_rs1 = 1'b1;
        issue_rs1     = AW'(5);
        issue_wr      = 1'b1;
        issue_rd      = AW'(6);
        alu_valid     = 1'b1;
        alu_rd        = AW'(5);
        alu_data      = 32'hDEAD;
        #1;
        check("raw_stall", 64'(issue_stall), 64'd1);
        check("raw_alu_ready", 64'(alu_ready), 64'd1);
        step();
        alu_valid = 1'b0;
        #1;
        check("raw_wr_en",   64'(rf_wr_en),      64'd1);
        check("raw_rd",      64'(rf_rd),         64'd5);
        check("raw_data",    64'(rf_write_data), 64'hDEAD);
        check("raw_unstall", 64'(issue_stall),   64'd0);
        step();
        idle();
        check("raw_x6_set", 64'(pending), 64'h0000_0040);
        check("raw_wr_en_off", 64'(rf_wr_en), 64'd0);
        check("hold_rd",   64'(rf_rd),         64'd5);
        check("hold_data", 64'(rf_write_data), 64'hDEAD);
        alu_valid = 1'b1;
        alu_rd    = AW'(6);
        alu_data  = 32'h66;
        step();
        idle();
        check("x6_clear", 64'(pending), 64'd0);
        check("x6_err",   64'(err_spurious), 64'd0);

        // Flush wipes pending and overrides a same-cycle issue; late wb is benign
        issue_write(AW'(3));
        issue_write(AW'(7));
        exp_pend = (NUM_REGS'(1) << 3) | (NUM_REGS'(1) << 7);
        check("fl_pending", 64'(pending), 64'(exp_pend));
        idle();
        flush       = 1'b1;
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_rd    = AW'(9);
        step();
        idle();
        check("fl_pending_zero", 64'(pending), 64'd0);
        step();
        step();
        lsu_valid = 1'b1;
        lsu_rd    = AW'(3);
        lsu_data  = 32'h333;
        #1;
        check("fl_lsu_ready", 64'(lsu_ready), 64'd1);
        step();
        idle();
        check("fl_wr_en", 64'(rf_wr_en),      64'd1);
        check("fl_rd",    64'(rf_rd),         64'd3);
        check("fl_data",  64'(rf_write_data), 64'h333);
        check("fl_err",   64'(err_spurious),  64'd0);

        // Spurious write-back to never-issued x4 sets a sticky error
        lsu_valid = 1'b1;
        lsu_rd    = AW'(4);
        lsu_data  = 32'h444;
        step();
        idle();
        check("sp_wr_en", 64'(rf_wr_en), 64'd1);
        check("sp_rd",    64'(rf_rd),    64'd4);
        check("sp_err",   64'(err_spurious), 64'd1);
        step();
        step();
        check("sp_err_sticky", 64'(err_spurious), 64'd1);

        // Asynchronous reset while a write is on the port
        issue_write(AW'(8));
        idle();
        alu_valid   = 1'b1;
        alu_rd      = AW'(8);
        alu_data    = 32'h888;
        issue_valid = 1'b1;
        issue_wr    = 1'b1;
        issue_rd    = AW'(9);
        step();
        idle();
        check("ar_wr_en_pre",   64'(rf_wr_en), 64'd1);
        check("ar_pending_pre", 64'(pending),  64'h0000_0200);
        #2;
        reset = 1'b1;
        #1;
        check("ar_wr_en",   64'(rf_wr_en),      64'd0);
        check("ar_pending", 64'(pending),       64'd0);
        check("ar_rd",      64'(rf_rd),         64'd0);
        check("ar_data",    64'(rf_write_data), 64'd0);
        check("ar_err",     64'(err_spurious),  64'd0);
        step();
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule
`default_nettype wire
